// File: rtl/ustack.sv
// Microcode call/return stack: circular LIFO of 12-bit return addresses with
// saturating occupancy, sticky overflow/underflow flags and synchronous clear.
module ustack #(
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clken,
    input  logic                           clr,
    input  logic                           call,
    input  logic                           ret,
    input  logic [0:11]                    pushADDR,
    output logic [0:11]                    dispRET,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           empty,
    output logic                           full,
    output logic                           stkOVF,
    output logic                           stkUNF
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);

    logic [0:11]   mem [DEPTH];
    logic [PW-1:0] tp;
    logic [PW-1:0] tp_inc;
    logic [PW-1:0] tp_dec;
    logic [PW-1:0] wr_ptr;
    logic          wr_en;

    assign tp_inc = tp + PW'(1);
    assign tp_dec = tp - PW'(1);
    assign empty  = (depth == '0);
    assign full   = (depth == DMAX);

    // call+ret on a non-empty stack replaces the top in place; otherwise a call
    // writes one slot above the current top (overwriting the oldest when full).
    always_comb begin
        wr_en  = 1'b0;
        wr_ptr = tp_inc;
        if (clken && !clr && call) begin
            wr_en  = 1'b1;
            wr_ptr = (ret && !empty) ? tp : tp_inc;
        end
    end

    // Array contents carry no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pushADDR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp     <= '0;
            depth  <= '0;
            stkOVF <= 1'b0;
            stkUNF <= 1'b0;
        end else if (clken) begin
            if (clr) begin
                tp     <= '0;
                depth  <= '0;
                stkOVF <= 1'b0;
                stkUNF <= 1'b0;
            end else if (call && ret) begin
                if (empty) begin
                    tp     <= tp_inc;
                    depth  <= DW'(1);
                    stkUNF <= 1'b1;
                end
            end else if (call) begin
                tp <= tp_inc;
                if (full) stkOVF <= 1'b1;
                else      depth  <= depth + DW'(1);
            end else if (ret) begin
                if (empty) begin
                    stkUNF <= 1'b1;
                end else begin
                    tp    <= tp_dec;
                    depth <= depth - DW'(1);
                end
            end
        end
    end

    assign dispRET = empty ? 12'o0000 : mem[tp];

endmodule

// File: tb/tb_ustack.sv
// Directed bench for ustack: a queue models the stack contents; every step
// compares top-of-stack, occupancy and flags against the model.
module tb_ustack;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clken = 1'b1;
    logic        clr = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [0:11] pushADDR = '0;
    logic [0:11] dispRET;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic        empty, full, stkOVF, stkUNF;

    int errors = 0;
    int checks = 0;
    int sb[$];
    bit eovf = 1'b0;
    bit eunf = 1'b0;

    ustack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clken(clken), .clr(clr), .call(call), .ret(ret),
        .pushADDR(pushADDR), .dispRET(dispRET), .depth(depth), .empty(empty),
        .full(full), .stkOVF(stkOVF), .stkUNF(stkUNF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] etop;
        etop = (sb.size() != 0) ? sb[sb.size()-1] : 0;
        chk({tag, ".dispRET"}, 32'(dispRET), etop);
        chk({tag, ".depth"},   32'(depth),   32'(sb.size()));
        chk({tag, ".empty"},   32'(empty),   32'(sb.size() == 0));
        chk({tag, ".full"},    32'(full),    32'(sb.size() == DEPTH));
        chk({tag, ".stkOVF"},  32'(stkOVF),  32'(eovf));
        chk({tag, ".stkUNF"},  32'(stkUNF),  32'(eunf));
    endtask

    // One clock step with the given controls; the model is updated alongside.
    task automatic op(input string tag, input bit c, input bit r, input bit cl,
                      input bit en, input logic [11:0] a);
        call = c; ret = r; clr = cl; clken = en; pushADDR = a;
        @(posedge clk); #1;
        call = 1'b0; ret = 1'b0; clr = 1'b0; clken = 1'b1;
        if (en) begin
            if (cl) begin
                sb.delete(); eovf = 1'b0; eunf = 1'b0;
            end else if (c && r) begin
                if (sb.size() != 0) sb[sb.size()-1] = int'(a);
                else begin sb.push_back(int'(a)); eunf = 1'b1; end
            end else if (c) begin
                if (sb.size() == DEPTH) begin void'(sb.pop_front()); eovf = 1'b1; end
                sb.push_back(int'(a));
            end else if (r) begin
                if (sb.size() != 0) void'(sb.pop_back());
                else eunf = 1'b1;
            end
        end
        check_all(tag);
    endtask

    initial begin
        #1;
        check_all("reset_held");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("reset_released");
        op("ret_empty", 0, 1, 0, 1, 0);

        // Basic LIFO
        op("clr0", 0, 0, 1, 1, 0);
        op("push_1234", 1, 0, 0, 1, 12'o1234);
        op("push_0017", 1, 0, 0, 1, 12'o0017);
        op("push_7777", 1, 0, 0, 1, 12'o7777);
        op("pop_a", 0, 1, 0, 1, 0);
        op("pop_b", 0, 1, 0, 1, 0);
        op("pop_c", 0, 1, 0, 1, 0);
        op("idle", 0, 0, 0, 1, 0);

        // Overflow with pointer wrap on push and pop
        for (int i = 1; i <= 17; i++) op("ovf_push", 1, 0, 0, 1, 12'(i));
        for (int i = 0; i < 16; i++)  op("ovf_pop", 0, 1, 0, 1, 0);
        op("unf_pop", 0, 1, 0, 1, 0);

        // Simultaneous call & ret
        op("clr1", 0, 0, 1, 1, 0);
        op("push_A", 1, 0, 0, 1, 12'o0100);
        op("push_B", 1, 0, 0, 1, 12'o0200);
        op("tail_replace", 1, 1, 0, 1, 12'o0300);
        op("pop_after_tail", 0, 1, 0, 1, 0);
        op("clr2", 0, 0, 1, 1, 0);
        op("callret_empty", 1, 1, 0, 1, 12'o4321);

        // Enable gating and clear priority
        op("dis_call", 1, 0, 0, 0, 12'o5555);
        op("dis_ret", 0, 1, 0, 0, 0);
        op("dis_clr", 0, 0, 1, 0, 0);
        op("push_pre_ovf", 1, 0, 0, 1, 12'o0042);
        op("clr_call", 1, 0, 1, 1, 12'o0666);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) op("ar_push", 1, 0, 0, 1, 12'(12'o0070 + i));
        rst = 1'b0;
        #2;
        sb.delete(); eovf = 1'b0; eunf = 1'b0;
        check_all("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("after_async_reset");
        op("post_reset_push", 1, 0, 0, 1, 12'o3333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ustack.md
# ustack

Microcode call/return stack for the KS-10 microsequencer. On a microcode CALL it saves a 12-bit return address. On a RETURN it pops that address. The top entry is driven as `dispRET[0:11]` into the dispatch logic, where the return select path ORs it into the next microcode address. The block is a circular LIFO with saturating occupancy, sticky overflow/underflow diagnostics, and a synchronous clear for console/halt recovery.

## Interface
- `DEPTH`, default 16: number of stack entries; power of two, ≥ 2.
- `clk`  in  1  CPU clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `clken`  in  1  clock enable; when 0, all state holds.
- `clr`  in  1  synchronous stack clear; gated by `clken`.
- `call`  in  1  push request (microcode CALL bit).
- `ret`  in  1  pop request (microcode RETURN dispatch).
- `pushADDR`  in  [0:11]  return address to save on `call`.
- `dispRET`  out  [0:11]  top-of-stack address; 0 when empty.
- `depth`  out  [$clog2(DEPTH+1)-1:0]  current occupancy, 0..DEPTH.
- `empty`  out  1  `depth == 0`.
- `full`  out  1  `depth == DEPTH`.
- `stkOVF`  out  1  sticky: a push occurred while full.
- `stkUNF`  out  1  sticky: a pop occurred while empty.

## Operation
- **Storage**
  - `DEPTH`×12 register array.
  - Top pointer `tp`, mod DEPTH. It indexes the most recent entry.
  - Occupancy counter `depth`.
- **Output**
  - `dispRET = (depth != 0) ? mem[tp] : 12'o0000`.
  - Purely a function of registered state, with no combinational path from inputs.
- **Priority** per enabled edge (`clken = 1`): `clr` > (`call`&`ret`) > `call` > `ret`.
- **clr**
  - `depth` ← 0 and `tp` ← 0.
  - `stkOVF` and `stkUNF` ← 0.
  - Array contents are don't-care.
- **call only**
  - `tp` ← `tp+1` (wraps), then `mem[tp+1]` ← `pushADDR`.
  - If `depth < DEPTH`, `depth` increments.
  - If full, the oldest entry is silently overwritten, `depth` stays DEPTH, and `stkOVF` ← 1.
- **ret only**
  - If `depth > 0`, `tp` ← `tp−1` (wraps) and `depth` decrements.
  - If empty, there is no state change except `stkUNF` ← 1.
- **call & ret together** (return-then-call, i.e. tail-replace)
  - If `depth > 0`, `mem[tp]` ← `pushADDR`; `tp` and `depth` are unchanged.
  - If empty, behaves as a push (`depth` → 1) and sets `stkUNF` ← 1.
- **Idle / disabled**
  - With `clken = 0`, or none of `call`, `ret`, `clr` asserted, all state holds.
- **Flags**
  - `stkOVF` and `stkUNF` are cleared only by `rst` or `clr`.

## Timing
- **Reset** (`rst` = 0, asynchronous): immediately `depth` = 0, `tp` = 0, `stkOVF` = 0, `stkUNF` = 0. Therefore `dispRET` = 0, `empty` = 1, `full` = 0.
- **Reset deassertion** is synchronized by the system reset logic. The first enabled edge after release is a normal cycle.
- **Latency**: a `call` sampled at edge N makes `pushADDR` visible on `dispRET` after edge N, i.e. usable by the dispatch select in cycle N+1.
- **Back-to-back calls** are allowed every cycle.
- **`ret` at edge N** exposes the previous entry (or 0) after edge N.
- **Boundary cases**
  - Pointer wrap DEPTH−1 → 0 on push, and 0 → DEPTH−1 on pop; both are transparent.
  - Asserting `rst` mid-sequence discards all entries.
  - `call` and `ret` with `clken = 0` are ignored.
  - `clr` with `clken = 0` is ignored.

## Test plan
- **Reset values**: release reset -> `depth` = 0, `empty` = 1, `dispRET` = 0, both flags 0; then `ret` -> `stkUNF` = 1, `depth` stays 0.
- **Basic LIFO**: push 0o1234, 0o0017, 0o7777 -> `dispRET` reads 0o7777; pops give 0o0017, then 0o1234, then 0 with `empty` = 1 and no flags.
- **Overflow (`DEPTH` = 16)**: push values 1..17.
  - After the 17th push: `full` = 1, `stkOVF` = 1, `depth` = 16.
  - 16 pops read 17 down to 2.
  - The next pop sets `stkUNF` = 1.
- **Simultaneous call & ret**: stack holds A=0o0100, B=0o0200; assert `call`+`ret` with 0o0300 -> `depth` stays 2, `dispRET` = 0o0300; one pop -> 0o0100.
- **Enable and clear**: with `clken` = 0, pulse `call`/`ret`/`clr` -> no change; with `clken` = 1, `clr`+`call` -> `depth` = 0 and flags cleared (clr wins).
- **Async reset**: assert `rst` low between clock edges while `depth` = 5 -> outputs reach reset values without a clock edge.
